// File: rtl/delay_sched_pkg.sv
// Shared definitions for the two-requester delay scheduler: FSM encoding,
// requester count and the round-robin pick helper.
package delay_sched_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Both requesting: the one that was not granted last wins; otherwise the sole requester.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] req, input logic last);
        rr_pick = (req == 2'b11) ? ~last : req[1];
    endfunction

endpackage

// File: rtl/delay_sched_if.sv
// Request/grant bundle between client FSMs (master) and the delay scheduler (slave).
interface delay_sched_if #(parameter int unsigned N = 8);
    import delay_sched_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] cancel;
    logic [N-1:0]       len0;
    logic [N-1:0]       len1;
    logic               hold;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] done;
    logic               busy;
    logic               owner;
    logic [N-1:0]       count;

    modport master (
        output req, cancel, len0, len1, hold,
        input  ack, done, busy, owner, count
    );

    modport slave (
        input  req, cancel, len0, len1, hold,
        output ack, done, busy, owner, count
    );

endinterface

// File: rtl/delay_sched_load_counter.sv
// Loadable N-bit down-counter that saturates at zero; clear beats load beats decrement.
module load_counter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         zero
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Next counter value.
    always_comb begin
        q_d = q_q;
        if (syn_clr) begin
            q_d = {N{1'b0}};
        end else if (load) begin
            q_d = d;
        end else if (en && !zero) begin
            q_d = q_q - {{(N-1){1'b0}}, 1'b1};
        end else begin
            q_d = q_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= {N{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign zero = (q_q == {N{1'b0}});
    assign q    = q_q;

endmodule

// File: rtl/delay_sched.sv
// Two-requester delay scheduler: round-robin grant, shared down-counter,
// one-cycle done pulse to the owner.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic          clk,
    input  logic          reset,
    delay_sched_if.slave  bus
);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               grant_s;
    logic [N-1:0]       len_sel_s;
    logic [N-1:0]       count_s;
    logic               zero_s;
    logic               load_s;
    logic               clr_s;
    logic               en_s;
    logic [NUM_REQ-1:0] ack_s;
    logic [NUM_REQ-1:0] done_s;

    assign grant_s   = rr_pick(bus.req, owner_q);
    assign len_sel_s = grant_s ? bus.len1 : bus.len0;

    // Next state, counter controls and grant/done pulses.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        load_s  = 1'b0;
        clr_s   = 1'b0;
        en_s    = 1'b0;
        ack_s   = 2'b00;
        done_s  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    ack_s   = grant_s ? 2'b10 : 2'b01;
                    load_s  = 1'b1;
                    owner_d = grant_s;
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (bus.cancel[owner_q]) begin
                    clr_s   = 1'b1;
                    state_d = ST_IDLE;
                end else if (zero_s) begin
                    state_d = ST_DONE;
                end else if (bus.hold) begin
                    en_s    = 1'b0;
                end else begin
                    en_s    = 1'b1;
                end
            end
            ST_DONE: begin
                done_s  = owner_q ? 2'b10 : 2'b01;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and owner registers; owner starts at 1 so requester 0 wins first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    load_counter #(.N(N)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .syn_clr (clr_s),
        .load    (load_s),
        .en      (en_s),
        .d       (len_sel_s),
        .q       (count_s),
        .zero    (zero_s)
    );

    // Pulses are suppressed while reset is applied.
    assign bus.ack   = reset ? ack_s  : 2'b00;
    assign bus.done  = reset ? done_s : 2'b00;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.owner = owner_q;
    assign bus.count = count_s;

endmodule

// File: doc/delay_sched.md
# delay_sched

Two-requester delay scheduler that shares one loadable N-bit down-counter. Each requester asks for a delay of `len` cycles. The block arbitrates round-robin, loads the counter, counts it down to zero and returns a one-cycle `done` pulse to the owner. It sits between client FSMs needing timed waits and the single shared counter datapath.

## Interface
- `N`, default 8: counter and length width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `req`  in  2  per-requester delay request; held high until `ack`.
- `len0`  in  N  delay length for requester 0; sampled in its `ack` cycle.
- `len1`  in  N  delay length for requester 1; sampled in its `ack` cycle.
- `cancel`  in  2  per-requester abort; acts only for the current owner.
- `hold`  in  1  freezes the counter while counting.
- `ack`  out  2  one-cycle grant pulse.
- `done`  out  2  one-cycle completion pulse to the owner.
- `busy`  out  1  high in COUNT and DONE.
- `owner`  out  1  index of the current or last granted requester.
- `count`  out  N  live counter value.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If any `req` is high, grant one: `ack[i]=1` this cycle (combinational from state and `req`).
  - `count <= len_i`, `owner <= i`, next state COUNT.
  - No request: stay in IDLE, counter unchanged.
- Arbitration: round-robin on `owner`.
  - If both request, grant the index != `owner`.
  - If one requests, grant it.
  - `owner` resets to 1, so requester 0 wins the first contention.
- COUNT, in priority order:
  - `cancel[owner]`: go to IDLE, counter cleared to 0, no `done`.
  - else `count==0`: go to DONE.
  - else `hold`: count unchanged.
  - else `count <= count-1`.
- `cancel` of the non-owner is ignored in every state.
- DONE: `done[owner]=1` for exactly one cycle, then IDLE. `cancel` is ignored in DONE.
- `len=0` is legal. The owner still gets `done`, with minimum latency.
- Arithmetic: unsigned, N bits. The counter never wraps, because decrement is blocked at 0. `len` of 2**N-1 is legal.
- `req` is not re-sampled after `ack`. If `req[i]` is still high in the cycle after DONE, requester i competes again, subject to round-robin.
- Reset (`reset=0` at an edge), including mid-operation:
  - state IDLE, `count=0`, `owner=1`.
  - `ack=0`, `done=0`, `busy=0`.
  - No `done` is emitted for an aborted delay.

## Timing
- Grant cycle g: `ack` is high in g. `count=len` and `busy=1` from g+1.
- Without `hold`, `count` reaches 0 at g+1+len. DONE, and therefore `done`, is in cycle g+2+len.
- Earliest next `ack` is g+3+len, so a back-to-back grant gap is 3+len cycles.
- Each `hold` cycle during COUNT adds exactly one cycle of latency.
- `cancel` in COUNT at cycle c: IDLE at c+1, and a new `ack` is possible at c+1.

## Structure
- Shared package `delay_sched_pkg`: state encoding (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and requester count constant (2).
- Sub-module `load_counter` (param N):
  - Inputs: `clk`, `reset`, `syn_clr`, `load`, `en`, `d`.
  - Outputs: `q`, `zero`.
  - Priority: `syn_clr` > `load` > `en` decrement.
  - Decrement is suppressed when `zero` is high.
- Top level contains the FSM, the round-robin arbiter and the `len` mux.

## Test plan
- Reset, then `req=01`, `len0=3`:
  - `ack=01` in cycle 0; `count` goes 3,2,1,0 in cycles 1–4.
  - `done=01` in cycle 5 only; `busy` low in cycle 6.
- `req=11` held continuously, `len0=len1=1`:
  - Grants alternate 0,1,0.
  - Each `done` goes to the matching owner, with a 4-cycle grant spacing.
- `len0=0`: `ack` at g, `done=01` at g+2.
- `len1=5` with `hold=1` for 2 cycles mid-count: `done=10` arrives at g+9 instead of g+7.
- `len0=10`, `cancel=01` when `count=6`:
  - IDLE next cycle, `count=0`, no `done`.
  - `cancel=10` pulsed earlier has no effect.
- `reset=0` asserted while in COUNT with `count=4`:
  - Next cycle: IDLE, `count=0`, `busy=0`, `owner=1`, no `done`.
  - After release, with `req=11`, requester 0 is granted first.
